// File: rtl/key_expand_seq.sv
// key_expand_seq: AES key schedule, one 32-bit word per clock.
// Holds w[0..Nw-1] and serves 128-bit round keys by index.
module key_expand_seq #(
  parameter int NK_MAX = 8,
  parameter int RK_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           keylen,
  input  logic [0:32*NK_MAX-1] key,
  output logic                 busy,
  output logic                 done,
  output logic                 sched_valid,
  input  logic [3:0]           rk_idx,
  output logic [0:127]         rk
);

  localparam int KW    = $clog2(NK_MAX);
  localparam int DEPTH = 64;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      2'd0:    return 4'd4;
      2'd1:    return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_keylen;
  logic [5:0]  r_i;
  logic [2:0]  r_mod;
  logic [7:0]  r_rcon;
  logic        r_sched_valid;
  logic [31:0] r_w [DEPTH];

  logic [31:0] w_kw [NK_MAX];
  logic [3:0]  w_nk_in;
  logic        w_start_ok;
  logic [3:0]  w_nk;
  logic [2:0]  w_nk_m1;
  logic [3:0]  w_nr;
  logic [5:0]  w_last;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic        w_rot;
  logic        w_sub8;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_temp;
  logic [31:0] w_new;
  logic        w_rk_hit;
  logic [0:127] w_rk_cmb;

  for (genvar g = 0; g < NK_MAX; g++) begin : g_kw
    assign w_kw[g] = key[32*g +: 32];
  end

  assign w_nk_in    = nk_of(keylen);
  assign w_start_ok = start && (r_state == IDLE)
                    && (keylen != 2'd3)
                    && (int'(w_nk_in) <= NK_MAX);

  assign w_nk    = nk_of(r_keylen);
  assign w_nk_m1 = w_nk[2:0] - 3'd1;
  assign w_nr    = w_nk + 4'd6;
  assign w_last  = {w_nk, 2'b00} + 6'd27;

  assign w_prev = r_w[r_i - 6'd1];
  assign w_back = r_w[r_i - {2'b00, w_nk}];
  assign w_rot  = (r_mod == 3'd0);
  assign w_sub8 = w_nk[3] && (r_mod == 3'd4);

  assign w_sub_in = w_rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  assign w_sub_out = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                      sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};

  // Per-word transform: rotate+sub+rcon at Nk boundaries, sub-only mid AES-256 block
  always_comb begin
    w_temp = w_prev;
    unique case (1'b1)
      w_rot:   w_temp = w_sub_out ^ {r_rcon, 24'h0};
      w_sub8:  w_temp = w_sub_out;
      default: w_temp = w_prev;
    endcase
  end

  assign w_new = w_back ^ w_temp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_nxt = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (r_i == w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word counter, i mod Nk, running Rcon and schedule-valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keylen      <= 2'd0;
      r_i           <= 6'd0;
      r_mod         <= 3'd0;
      r_rcon        <= 8'h01;
      r_sched_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_keylen      <= keylen;
            r_i           <= {2'b00, w_nk_in};
            r_mod         <= 3'd0;
            r_rcon        <= 8'h01;
            r_sched_valid <= 1'b0;
          end
        end
        EXPAND: begin
          r_i   <= r_i + 6'd1;
          r_mod <= (r_mod == w_nk_m1) ? 3'd0 : r_mod + 3'd1;
          if (w_rot)
            r_rcon <= {r_rcon[6:0], 1'b0}
                    ^ (r_rcon[7] ? 8'h1b : 8'h00);
          // valid rises together with done
          if (r_i == w_last) r_sched_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Word storage: key words on start, one derived word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (w_start_ok) begin
      for (int j = 0; j < NK_MAX; j++)
        if (j < int'(w_nk_in)) r_w[6'(j)] <= w_kw[KW'(j)];
    end else if (r_state == EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  assign sched_valid = r_sched_valid;

  assign w_rk_hit = r_sched_valid && (rk_idx <= w_nr);
  assign w_rk_cmb = w_rk_hit
                  ? {r_w[{rk_idx, 2'd0}], r_w[{rk_idx, 2'd1}],
                     r_w[{rk_idx, 2'd2}], r_w[{rk_idx, 2'd3}]}
                  : 128'h0;

  if (RK_REG != 0) begin : g_rk_reg
    logic [0:127] r_rk;
    // Registered round-key read port
    always_ff @(posedge clk) begin
      if (rst) r_rk <= 128'h0;
      else     r_rk <= w_rk_cmb;
    end
    assign rk = r_rk;
  end else begin : g_rk_cmb
    assign rk = w_rk_cmb;
  end

endmodule

// File: tb/tb_key_expand_seq.sv
// tb_key_expand_seq: directed FIPS-197 vectors for key_expand_seq.
// Timing, control and round-key values checked with immediate assertions.
module tb_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   keylen;
  logic [0:255] key;
  logic         busy;
  logic         done;
  logic         sched_valid;
  logic [3:0]   rk_idx;
  logic [0:127] rk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  key_expand_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .keylen      (keylen),
    .key         (key),
    .busy        (busy),
    .done        (done),
    .sched_valid (sched_valid),
    .rk_idx      (rk_idx),
    .rk          (rk)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] kl,
                             input logic [255:0] k);
    keylen = kl;
    key    = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Count edges after the start edge until done; optional stray start at edge poke
  task automatic wait_done(input string tag, input int exp, input int poke);
    int n;
    n = 0;
    for (int e = 1; e <= 80; e++) begin
      if (e == poke) begin
        start  = 1'b1;
        keylen = 2'd2;
        key    = '1;
      end
      tick();
      if (e == poke) start = 1'b0;
      if (done === 1'b1) begin
        n = e;
        break;
      end
    end
    chk(tag, 128'(n), 128'(exp));
  endtask

  task automatic read_rk(input logic [3:0] idx);
    rk_idx = idx;
    tick();
  endtask

  initial begin
    int seen;
    rst    = 1'b1;
    start  = 1'b0;
    keylen = 2'd0;
    key    = '0;
    rk_idx = 4'd0;
    tick();
    tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(sched_valid), 128'(0));
    chk("rst_rk", rk, 128'h0);
    rst = 1'b0;
    tick();

    pulse_start(2'd3, '1);
    chk("kl3_busy", 128'(busy), 128'(0));
    chk("kl3_valid", 128'(sched_valid), 128'(0));

    rk_idx = 4'd10;
    pulse_start(2'd0, K128);
    chk("k128_busy", 128'(busy), 128'(1));
    chk("k128_valid_lo", 128'(sched_valid), 128'(0));
    wait_done("k128_done_edge", 40, 10);
    tick();
    chk("k128_done_pulse", 128'(done), 128'(0));
    chk("k128_idle", 128'(busy), 128'(0));
    chk("k128_valid", 128'(sched_valid), 128'(1));
    chk("k128_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    pulse_start(2'd0, '0);
    chk("zero_b2b_busy", 128'(busy), 128'(1));
    chk("zero_valid_lo", 128'(sched_valid), 128'(0));
    wait_done("zero_done_edge", 40, 0);
    read_rk(4'd1);
    chk("zero_rk1", rk, 128'h62636363626363636263636362636363);
    read_rk(4'd10);
    chk("zero_rk10", rk, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    read_rk(4'd11);
    chk("zero_rk11", rk, 128'h0);
    read_rk(4'd0);
    chk("zero_rk0", rk, 128'h0);

    pulse_start(2'd1, K192);
    wait_done("k192_done_edge", 46, 0);
    read_rk(4'd12);
    chk("k192_rk12_w3", 128'(rk[96:127]), 128'(32'h01002202));
    read_rk(4'd0);
    chk("k192_rk0", rk, 128'h8e73b0f7da0e6452c810f32b809079e5);
    read_rk(4'd13);
    chk("k192_rk13", rk, 128'h0);

    pulse_start(2'd2, K256);
    wait_done("k256_done_edge", 52, 0);
    read_rk(4'd14);
    chk("k256_rk14_w3", 128'(rk[96:127]), 128'(32'h706c631e));
    read_rk(4'd15);
    chk("k256_rk15", rk, 128'h0);
    read_rk(4'd0);
    chk("k256_rk0", rk, 128'h603deb1015ca71be2b73aef0857d7781);

    pulse_start(2'd2, K256);
    for (int e = 1; e < 20; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_valid", 128'(sched_valid), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_rk_rst", rk, 128'h0);
    read_rk(4'd0);
    chk("abort_rk0", rk, 128'h0);
    seen = 0;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (done !== 1'b0 || sched_valid !== 1'b0) seen++;
    end
    chk("abort_no_done", 128'(seen), 128'(0));

    pulse_start(2'd2, K256);
    wait_done("rerun_done_edge", 52, 0);
    read_rk(4'd14);
    chk("rerun_rk14_w3", 128'(rk[96:127]), 128'(32'h706c631e));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_expand_seq.md
KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

Interface
REQ-001 SHALL have parameter NK_MAX, default 8: largest supported key in 32-bit words; legal values 4, 6, 8; sets key width and storage depth.
REQ-002 SHALL have parameter RK_REG, default 1: round-key read latency; 1 = registered output, 0 = combinational output.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to expand the key.
REQ-006 SHALL have port keylen, input, 2: key length; 0 = AES-128, 1 = AES-192, 2 = AES-256; sampled with start.
REQ-007 SHALL have port key, input, [0:32*NK_MAX-1]: cipher key, MSB-aligned; bit 0 is the key MSB; the AES-128 key occupies key[0:127].
REQ-008 SHALL have port busy, output, 1: expansion in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when the schedule is complete.
REQ-010 SHALL have port sched_valid, output, 1: a complete schedule is stored.
REQ-011 SHALL have port rk_idx, input, 4: round-key index, 0..Nr.
REQ-012 SHALL have port rk, output, [0:127]: round key rk_idx, equal to words w[4*rk_idx] to w[4*rk_idx+3].

Function
REQ-013 SHALL set Nk/Nr to 4/10, 6/12 and 8/14 for keylen 0/1/2; Nw = 4*(Nr+1) words, i.e. 44/52/60.
REQ-014 SHALL treat keylen = 3, or any keylen whose Nk exceeds NK_MAX, as invalid: start is ignored and no state changes.
REQ-015 SHALL use FSM states IDLE, EXPAND, DONE, with reset state IDLE.
REQ-016 SHALL, in IDLE on a valid start: latch keylen, write w[0..Nk-1] from key, set i = Nk, clear sched_valid, and go to EXPAND.
REQ-017 SHALL write exactly one word w[i] per EXPAND cycle, then increment i; after writing w[Nw-1] it SHALL go to DONE.
REQ-018 SHALL compute each word as follows: temp = w[i-1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) xor {Rcon[i/Nk],24'h0}.
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - Then w[i] = w[i-Nk] xor temp.
REQ-019 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, and SHALL use the FIPS-197 S-box.
REQ-020 SHALL track i mod Nk and the Rcon index with counters, with no divider, and SHALL use a single shared 4-S-box SubWord instance.
REQ-021 SHALL, in DONE, assert done for exactly one cycle, set sched_valid, and return to IDLE.
REQ-022 SHALL assert done Nw-Nk clock edges after the edge that sampled start: 40 for AES-128, 46 for AES-192, 52 for AES-256.
REQ-023 SHALL drive busy = 1 in EXPAND and DONE, and 0 in IDLE.
REQ-024 SHALL ignore start while busy; key and keylen changes after the start edge SHALL have no effect.
REQ-025 SHALL allow start in the cycle immediately after done; that start begins a new expansion.
REQ-026 SHALL keep sched_valid low from the start edge until done for the new schedule.
REQ-027 SHALL, with RK_REG = 1, present rk for the rk_idx sampled one edge earlier; with RK_REG = 0, rk SHALL follow rk_idx combinationally.
REQ-028 SHALL drive rk = 0 when rk_idx > Nr or sched_valid = 0.

Reset
REQ-029 SHALL, when rst is high at a rising edge: go to IDLE, drive busy = 0, done = 0, sched_valid = 0 and i = 0, and clear the registered rk to 0.
REQ-030 SHALL let rst take priority over start; reset mid-expansion SHALL abort, and the partial schedule SHALL never become valid.
REQ-031 SHALL NOT require word storage to be cleared by reset.

Verification
REQ-032 SHALL pass this bench: AES-128 with an all-zero key -> done at edge 40; rk_idx 1 gives 62636363626363636263636362636363; rk_idx 10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-033 SHALL pass this bench: AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> rk_idx 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 SHALL pass this bench: AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done at edge 46; last word of rk_idx 12 is 01002202.
REQ-035 SHALL pass this bench: AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done at edge 52; last word of rk_idx 14 is 706c631e; rk_idx 15 gives 0.
REQ-036 SHALL pass this bench: start pulsed at edge 10 of an expansion is ignored, and done timing is unchanged; keylen = 3 with start leaves busy at 0.
REQ-037 SHALL pass this bench: rst asserted at edge 20 of an AES-256 expansion -> the next cycle shows busy = 0 and sched_valid = 0, no done pulse, and rk = 0; a following start completes normally.
